// File: rtl/iologic_cal_pkg.sv
// rtl/iologic_cal_pkg.sv - shared types and helpers for IOLOGIC delay calibration
package iologic_cal_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_CHECK,
        ST_STEP,
        ST_CENTER,
        ST_DONE,
        ST_FAIL
    } cal_state_t;

    localparam logic [7:0] DEFAULT_PATTERN = 8'h5A;

    // ceil(log2(ntap)), never below 1 so a tap bus always exists
    function automatic int tap_w(input int ntap);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < ntap) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/iologic_cal_chk.sv
// rtl/iologic_cal_chk.sv - counts consecutive matching training words at one tap
module iologic_cal_chk
    import iologic_cal_pkg::*;
#(
    parameter int         SAMPLES = 16,
    parameter logic [7:0] PATTERN = DEFAULT_PATTERN
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] rx_data,
    output logic       valid,
    output logic       pass
);

    localparam int CW = $clog2(SAMPLES + 1);

    logic [CW-1:0] cnt;
    logic          mismatch;

    assign mismatch = (rx_data != PATTERN);
    // a mismatch ends the check immediately; otherwise report on the last word
    assign valid    = en && (mismatch || (cnt == CW'(SAMPLES - 1)));
    assign pass     = en && !mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || valid) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/iologic_delay_cal.sv
// rtl/iologic_delay_cal.sv - sweeps IOLOGIC delay taps, finds the passing window and centres on it
module iologic_delay_cal
    import iologic_cal_pkg::*;
#(
    parameter int         NTAP    = 128,
    parameter int         SETTLE  = 8,
    parameter int         SAMPLES = 16,
    parameter logic [7:0] PATTERN = DEFAULT_PATTERN
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [7:0]               rx_data,
    input  logic                     cflag,
    output logic                     loadn,
    output logic                     move,
    output logic                     direction,
    output logic                     busy,
    output logic                     done,
    output logic                     fail,
    output logic [tap_w(NTAP)-1:0]   tap,
    output logic [tap_w(NTAP)-1:0]   win_lo,
    output logic [tap_w(NTAP)-1:0]   win_hi
);

    localparam int               TAP_W   = tap_w(NTAP);
    localparam int               CNT_W   = $clog2(SETTLE + 2);
    localparam logic [TAP_W-1:0] TAP_MAX = TAP_W'(NTAP - 1);

    cal_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [TAP_W-1:0] tap_n, win_lo_n, win_hi_n, target, target_n;
    logic [TAP_W:0]   win_sum;
    logic             win_valid, win_valid_n;
    logic             loadn_n, move_n, direction_n, busy_n, done_n, fail_n;
    logic             end_sweep;
    logic             chk_valid, chk_pass;

    iologic_cal_chk #(
        .SAMPLES (SAMPLES),
        .PATTERN (PATTERN)
    ) u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (state == ST_CHECK),
        .rx_data (rx_data),
        .valid   (chk_valid),
        .pass    (chk_pass)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            tap       <= '0;
            win_lo    <= '0;
            win_hi    <= '0;
            win_valid <= 1'b0;
            target    <= '0;
            loadn     <= 1'b1;
            move      <= 1'b0;
            direction <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            tap       <= tap_n;
            win_lo    <= win_lo_n;
            win_hi    <= win_hi_n;
            win_valid <= win_valid_n;
            target    <= target_n;
            loadn     <= loadn_n;
            move      <= move_n;
            direction <= direction_n;
            busy      <= busy_n;
            done      <= done_n;
            fail      <= fail_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        tap_n       = tap;
        win_lo_n    = win_lo;
        win_hi_n    = win_hi;
        win_valid_n = win_valid;
        target_n    = target;
        loadn_n     = loadn;
        move_n      = 1'b0;
        direction_n = direction;
        busy_n      = busy;
        done_n      = done;
        fail_n      = fail;
        end_sweep   = 1'b0;

        case (state)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (start) begin
                    state_n     = ST_LOAD;
                    cnt_n       = '0;
                    tap_n       = '0;
                    win_lo_n    = '0;
                    win_hi_n    = '0;
                    win_valid_n = 1'b0;
                    loadn_n     = 1'b0;
                    direction_n = 1'b0;
                    busy_n      = 1'b1;
                    done_n      = 1'b0;
                    fail_n      = 1'b0;
                end
            end
            ST_LOAD: begin
                if (cnt == CNT_W'(1)) begin
                    state_n = ST_SETTLE;
                    cnt_n   = '0;
                    loadn_n = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_SETTLE: begin
                if (cnt == CNT_W'(SETTLE - 1)) begin
                    state_n = ST_CHECK;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_CHECK: begin
                if (chk_valid) begin
                    if (chk_pass) begin
                        if (!win_valid) begin
                            win_lo_n = tap;
                        end
                        win_hi_n    = tap;
                        win_valid_n = 1'b1;
                    end
                    if ((!chk_pass && win_valid) || (tap == TAP_MAX)) begin
                        end_sweep = 1'b1;
                    end else begin
                        state_n = ST_STEP;
                    end
                end
            end
            ST_STEP: begin
                if (cflag) begin
                    end_sweep = 1'b1;
                end else begin
                    move_n  = 1'b1;
                    tap_n   = tap + 1'b1;
                    cnt_n   = '0;
                    state_n = ST_SETTLE;
                end
            end
            ST_CENTER: begin
                // direction was raised on entry, so it is stable before the first pulse
                if (tap == target) begin
                    state_n = ST_DONE;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                end else if (cnt == CNT_W'(SETTLE)) begin
                    move_n = 1'b1;
                    tap_n  = tap - 1'b1;
                    cnt_n  = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        win_sum = {1'b0, win_lo_n} + {1'b0, win_hi_n};
        if (end_sweep) begin
            if (win_valid_n) begin
                state_n     = ST_CENTER;
                cnt_n       = '0;
                direction_n = 1'b1;
                target_n    = TAP_W'(win_sum >> 1);
            end else begin
                state_n = ST_FAIL;
                fail_n  = 1'b1;
                busy_n  = 1'b0;
            end
        end
    end

endmodule

// File: doc/iologic_delay_cal.md
IOLOGIC_DELAY_CAL -- requirements
Module: iologic_delay_cal

Interface
REQ-001 SHALL have parameter NTAP, default 128: number of IOLOGIC dynamic delay taps; tap width TAP_W = clog2(NTAP).
REQ-002 SHALL have parameter SETTLE, default 8: idle cycles after each delay change before sampling.
REQ-003 SHALL have parameter SAMPLES, default 16: consecutive words checked per tap.
REQ-004 SHALL have parameter PATTERN, default 8'h5A: expected training word.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  clock; rst_n  in  1  async reset, active-low.
REQ-006 SHALL have port start  in  1  one-cycle request to calibrate.
REQ-007 SHALL have port rx_data  in  8  gearbox output word, sampled synchronous to clk.
REQ-008 SHALL have port cflag  in  1  IOLOGIC delay-limit flag.
REQ-009 SHALL have port loadn  out  1  IOLOGIC LOADN, active-low load of default delay.
REQ-010 SHALL have port move  out  1  IOLOGIC MOVE, one-cycle step pulse.
REQ-011 SHALL have port direction  out  1  IOLOGIC DIRECTION, 0 = increase, 1 = decrease.
REQ-012 SHALL have ports busy, done, fail  out  1 each  status flags.
REQ-013 SHALL have ports tap, win_lo, win_hi  out  TAP_W each  current tap, passing-window bounds.

Function
REQ-014 SHALL implement states IDLE, LOAD, SETTLE, CHECK, STEP, CENTER, DONE, FAIL.
REQ-015 SHALL, on start in IDLE, DONE or FAIL, enter LOAD, drive loadn=0 for exactly 2 cycles, and set tap=0, busy=1, done=0, fail=0, window invalid.
REQ-016 SHALL ignore start while busy=1.
REQ-017 SHALL wait exactly SETTLE cycles in SETTLE after LOAD and after every move pulse.
REQ-018 SHALL, in CHECK, declare the tap passing iff all SAMPLES consecutive rx_data words equal PATTERN; the first mismatch ends CHECK early as fail.
REQ-019 SHALL, on the first passing tap, set win_lo=win_hi=tap; on each further contiguous passing tap, set win_hi=tap.
REQ-020 SHALL end the sweep on the first failing tap after a valid window, on tap==NTAP-1, or on cflag=1 sampled in STEP, whichever occurs first.
REQ-021 SHALL otherwise enter STEP: direction=0, one-cycle move=1, tap increments by one, then SETTLE.
REQ-022 SHALL, at sweep end with no valid window, enter FAIL: fail=1, busy=0, tap holds its value.
REQ-023 SHALL, at sweep end with a valid window, compute target=(win_lo+win_hi)>>1 using a TAP_W+1-bit sum.
REQ-024 SHALL, in CENTER, drive direction=1 and pulse move once per SETTLE+1 cycles, decrementing tap each pulse, until tap==target; then enter DONE with done=1 and busy=0.
REQ-025 SHALL never assert move on two adjacent cycles; direction SHALL be stable one cycle before and during move.
REQ-026 SHALL hold done, fail, tap and window outputs stable in DONE and FAIL until the next start.

Reset
REQ-027 SHALL on rst_n=0 asynchronously force IDLE, loadn=1, move=0, direction=0, busy=0, done=0, fail=0, tap=0, win_lo=0, win_hi=0, including mid-sweep and mid-CENTER.

Structure
REQ-028 SHALL place the state enum, TAP_W function and default PATTERN in shared package iologic_cal_pkg.
REQ-029 SHALL place the SAMPLES-word compare counter in sub-module iologic_cal_chk, which outputs pass/fail and a valid strobe.

Verification
REQ-030 Bench SHALL cover: data matches only at taps 20..40 -> win_lo=20, win_hi=40, final tap=30, done=1.
REQ-031 Bench SHALL cover: never matches -> fail=1 with tap=127 after a full sweep; move pulse count is 127.
REQ-032 Bench SHALL cover: matches at 10..12, then cflag=1 at tap 12 -> win 10..12, target 11, exactly one decrease pulse.
REQ-033 Bench SHALL cover: single corrupted word at tap 25 within 20..40 -> window closes at win_hi=24, target 22.
REQ-034 Bench SHALL cover: rst_n asserted during CENTER -> all outputs at reset values on the same cycle; the next start recalibrates cleanly.
REQ-035 Bench SHALL cover: start pulsed while busy -> no restart, result identical to an undisturbed run.
